// File: rtl/spi_xact_arbiter.sv
// spi_xact_arbiter
//
// Shares one SPI master between three requesters (0 = command/config path,
// 1 = calibration loader, 2 = trigger-level DAC writer). One requester is granted
// at a time in round-robin order. The block issues its word, waits for SPI_done or
// a timeout, then returns the received byte with a one-cycle acknowledge.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   req_i[2:0]       per-requester request level
//   req_dataN_i      16-bit SPI word from requester N
//   req_ssN_i        3-bit slave select from requester N
//   ack_o[2:0]       one-cycle completion pulse to the granted requester
//   err_o            one-cycle pulse with ack_o when the transaction timed out
//   rd_data_o        captured EEP_data (8'hFF on timeout), valid from the ack cycle
//   busy_o           high whenever the arbiter is not idle
//   spi_data_o       word to the SPI peripheral
//   ss_o             slave select to the SPI peripheral
//   wrt_spi_o        one-cycle transaction start strobe
//   spi_done_i       SPI peripheral completion strobe
//   eep_data_i       received byte from the SPI peripheral

module spi_xact_arbiter #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_i,
  input  logic [15:0] req_data0_i,
  input  logic [15:0] req_data1_i,
  input  logic [15:0] req_data2_i,
  input  logic [2:0]  req_ss0_i,
  input  logic [2:0]  req_ss1_i,
  input  logic [2:0]  req_ss2_i,
  output logic [2:0]  ack_o,
  output logic        err_o,
  output logic [7:0]  rd_data_o,
  output logic        busy_o,
  output logic [15:0] spi_data_o,
  output logic [2:0]  ss_o,
  output logic        wrt_spi_o,
  input  logic        spi_done_i,
  input  logic [7:0]  eep_data_i
);

  // Last counter value before the transaction is abandoned.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      state_q;
  logic [1:0]  rr_ptr_q;
  logic [1:0]  grant_q;
  logic [15:0] cnt_q;

  logic [1:0]  cand0, cand1, cand2;
  logic [1:0]  win_idx;
  logic [15:0] win_data;
  logic [2:0]  win_ss;

  // Search order starts at rr_ptr and wraps modulo 3.
  always_comb begin
    cand0 = 2'd0;
    cand1 = 2'd1;
    cand2 = 2'd2;
    case (rr_ptr_q)
      2'd1: begin
        cand0 = 2'd1;
        cand1 = 2'd2;
        cand2 = 2'd0;
      end
      2'd2: begin
        cand0 = 2'd2;
        cand1 = 2'd0;
        cand2 = 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    win_idx = cand2;
    if (req_i[cand0]) begin
      win_idx = cand0;
    end else if (req_i[cand1]) begin
      win_idx = cand1;
    end
  end

  always_comb begin
    win_data = req_data0_i;
    win_ss   = req_ss0_i;
    case (win_idx)
      2'd1: begin
        win_data = req_data1_i;
        win_ss   = req_ss1_i;
      end
      2'd2: begin
        win_data = req_data2_i;
        win_ss   = req_ss2_i;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 2'd0;
      grant_q    <= 2'd0;
      cnt_q      <= 16'd0;
      spi_data_o <= 16'h0000;
      ss_o       <= 3'b000;
      wrt_spi_o  <= 1'b0;
      ack_o      <= 3'b000;
      err_o      <= 1'b0;
      rd_data_o  <= 8'h00;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      wrt_spi_o <= 1'b0;
      ack_o     <= 3'b000;
      err_o     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|req_i) begin
            spi_data_o <= win_data;
            ss_o       <= win_ss;
            grant_q    <= win_idx;
            cnt_q      <= 16'd0;
            wrt_spi_o  <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          // A completion strobe this early cannot belong to our transaction.
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + 16'd1;
          if (spi_done_i) begin
            rd_data_o      <= eep_data_i;
            ack_o[grant_q] <= 1'b1;
            state_q        <= StDone;
          end else if (cnt_q == TimeoutLast) begin
            rd_data_o      <= 8'hFF;
            err_o          <= 1'b1;
            ack_o[grant_q] <= 1'b1;
            state_q        <= StDone;
          end
        end
        StDone: begin
          rr_ptr_q <= (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xact_arbiter.sv
// Testbench for spi_xact_arbiter: a transaction-level model predicts every output
// each cycle; directed tests add hand-computed literal expectations.

module tb_spi_xact_arbiter;

  localparam int T = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [15:0] d0 = 16'h0, d1 = 16'h0, d2 = 16'h0;
  logic [2:0]  s0 = 3'b0, s1 = 3'b0, s2 = 3'b0;
  logic        spi_done = 1'b0;
  logic [7:0]  eep = 8'h00;

  logic [2:0]  ack_o;
  logic        err_o;
  logic [7:0]  rd_data_o;
  logic        busy_o;
  logic [15:0] spi_data_o;
  logic [2:0]  ss_o;
  logic        wrt_spi_o;

  int errors = 0;
  int checks = 0;

  spi_xact_arbiter #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .req_data0_i(d0),
    .req_data1_i(d1),
    .req_data2_i(d2),
    .req_ss0_i  (s0),
    .req_ss1_i  (s1),
    .req_ss2_i  (s2),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .rd_data_o  (rd_data_o),
    .busy_o     (busy_o),
    .spi_data_o (spi_data_o),
    .ss_o       (ss_o),
    .wrt_spi_o  (wrt_spi_o),
    .spi_done_i (spi_done),
    .eep_data_i (eep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Transaction-level model ----------------
  // active: a transaction owns the SPI; age: cycles since the start strobe;
  // fin: the acknowledge cycle is current; last: most recently served requester.
  typedef struct {
    bit          active;
    bit          fin;
    int          age;
    int          g;
    int          last;
    logic [15:0] data;
    logic [2:0]  ss;
    logic [7:0]  rd;
    logic [2:0]  ack;
    bit          err;
    bit          wrt;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.active = 0; m.fin = 0; m.age = 0; m.g = 0; m.last = 2;
    m.data = 16'h0; m.ss = 3'b0; m.rd = 8'h0; m.ack = 3'b0; m.err = 0; m.wrt = 0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input logic [2:0] r,
                                        input logic done_in, input logic [7:0] e);
    model_t n = m;
    logic [15:0] words [3];
    logic [2:0]  sels [3];
    words[0] = d0; words[1] = d1; words[2] = d2;
    sels[0] = s0;  sels[1] = s1;  sels[2] = s2;
    n.ack = 3'b0; n.err = 0; n.wrt = 0;
    if (!m.active) begin
      for (int k = 1; k <= 3; k++) begin
        int idx = (m.last + k) % 3;
        if (!n.active && r[idx]) begin
          n.active = 1; n.fin = 0; n.age = 0; n.g = idx;
          n.data = words[idx]; n.ss = sels[idx]; n.wrt = 1;
        end
      end
    end else if (m.fin) begin
      n.active = 0; n.fin = 0; n.last = m.g;
    end else if (m.age == 0) begin
      n.age = 1;
    end else if (done_in) begin
      n.rd = e; n.fin = 1; n.ack = 3'(1 << m.g);
    end else if (m.age == T) begin
      n.rd = 8'hFF; n.err = 1; n.fin = 1; n.ack = 3'(1 << m.g);
    end else begin
      n.age = m.age + 1;
    end
    return n;
  endfunction

  model_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_step(m, req, spi_done, eep);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_spi_data", spi_data_o, m.data);
      chk("m_ss", ss_o, m.ss);
      chk("m_wrt", wrt_spi_o, m.wrt);
      chk("m_ack", ack_o, m.ack);
      chk("m_err", err_o, m.err);
      chk("m_rd_data", rd_data_o, m.rd);
      chk("m_busy", busy_o, m.active);
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrt(input int budget);
    int n = 0;
    while (!wrt_spi_o && n < budget) begin
      tick();
      n++;
    end
    chk("wrt_seen", wrt_spi_o, 1);
  endtask

  // Called in the strobe cycle: completes two WAIT cycles later.
  task automatic finish_xact(input logic [2:0] exp_ack, input logic [7:0] e);
    tick();
    tick();
    spi_done = 1'b1;
    eep = e;
    tick();
    spi_done = 1'b0;
    chk("fin_ack", ack_o, exp_ack);
    chk("fin_rd", rd_data_o, e);
    chk("fin_err", err_o, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_spi_data", spi_data_o, 16'h0000);
    chk("rst_ss", ss_o, 3'b000);
    chk("rst_wrt", wrt_spi_o, 0);
    chk("rst_ack", ack_o, 3'b000);
    chk("rst_err", err_o, 0);
    chk("rst_rd", rd_data_o, 8'h00);
    chk("rst_busy", busy_o, 0);
  endtask

  initial begin
    #1;
    check_reset_outputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 1.
    d1 = 16'hA5C3; s1 = 3'b100; req = 3'b010;
    tick();
    chk("t1_wrt", wrt_spi_o, 1);
    chk("t1_data", spi_data_o, 16'hA5C3);
    chk("t1_ss", ss_o, 3'b100);
    repeat (20) tick();
    chk("t1_no_ack_yet", ack_o, 3'b000);
    spi_done = 1'b1; eep = 8'h5A;
    tick();
    spi_done = 1'b0; req = 3'b000;
    chk("t1_ack", ack_o, 3'b010);
    chk("t1_rd", rd_data_o, 8'h5A);
    chk("t1_err", err_o, 0);
    tick();

    // Contention from reset: order 0,1,2.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    d0 = 16'h1111; d1 = 16'h2222; d2 = 16'h3333;
    s0 = 3'b001;   s1 = 3'b100;   s2 = 3'b000;
    req = 3'b111;
    begin
      logic [15:0] words [3];
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
      for (int k = 0; k < 3; k++) begin
        wait_wrt(10);
        chk("t2_order_data", spi_data_o, words[k]);
        finish_xact(3'(1 << k), 8'(8'h10 + k));
        req[k] = 1'b0;
      end
    end

    // Round-robin: grant 1, then req=011 serves 0 before 1.
    d0 = 16'h0A0A; d1 = 16'hBEEF;
    req = 3'b010;
    wait_wrt(10);
    chk("t3_first", spi_data_o, 16'hBEEF);
    finish_xact(3'b010, 8'h21);
    req = 3'b011;
    wait_wrt(10);
    chk("t3_second", spi_data_o, 16'h0A0A);
    finish_xact(3'b001, 8'h22);
    req = 3'b010;
    wait_wrt(10);
    chk("t3_third", spi_data_o, 16'hBEEF);
    finish_xact(3'b010, 8'h23);
    req = 3'b000;
    tick();

    // Timeout: ack+err T+1 cycles after the strobe.
    d2 = 16'hC0DE; s2 = 3'b000; req = 3'b100;
    tick();
    chk("t4_wrt", wrt_spi_o, 1);
    repeat (T) tick();
    chk("t4_not_yet", ack_o, 3'b000);
    tick();
    chk("t4_ack", ack_o, 3'b100);
    chk("t4_err", err_o, 1);
    chk("t4_rd", rd_data_o, 8'hFF);
    req = 3'b000;
    tick();
    // Completion coinciding with the timeout cycle wins.
    req = 3'b100;
    tick();
    chk("t4b_wrt", wrt_spi_o, 1);
    repeat (T) tick();
    spi_done = 1'b1; eep = 8'h3C;
    tick();
    spi_done = 1'b0; req = 3'b000;
    chk("t4b_ack", ack_o, 3'b100);
    chk("t4b_err", err_o, 0);
    chk("t4b_rd", rd_data_o, 8'h3C);
    tick();

    // Spurious completions in idle and in the strobe cycle.
    spi_done = 1'b1; eep = 8'h77;
    tick();
    spi_done = 1'b0;
    chk("t5_idle_ack", ack_o, 3'b000);
    chk("t5_idle_rd", rd_data_o, 8'h3C);
    chk("t5_idle_busy", busy_o, 0);
    req = 3'b001;
    tick();
    chk("t5_wrt", wrt_spi_o, 1);
    spi_done = 1'b1; eep = 8'h66;
    tick();
    spi_done = 1'b0;
    chk("t5_issue_ack", ack_o, 3'b000);
    chk("t5_issue_rd", rd_data_o, 8'h3C);
    finish_xact(3'b001, 8'h42);
    req = 3'b000;
    tick();

    // Reset mid-wait: outputs clear at once, pointer returns to 0.
    req = 3'b010;
    wait_wrt(10);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    req = 3'b011;
    wait_wrt(10);
    chk("t6_after_rst", spi_data_o, 16'h0A0A);
    finish_xact(3'b001, 8'h55);
    req = 3'b010;
    wait_wrt(10);
    chk("t6_next", spi_data_o, 16'hBEEF);
    finish_xact(3'b010, 8'h56);
    req = 3'b000;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
